// File: rtl/vx_tensor_wgmma_sequencer.sv
// Multi-warp tensor commit sequencer: per-warp metadata queues, round-robin warp
// selection, a fixed compute phase and NUM_WB valid/ready writeback beats per op.
module vx_tensor_wgmma_sequencer #(
  parameter int NUM_WARPS      = 4,
  parameter int NW_WIDTH       = 2,
  parameter int META_W         = 64,
  parameter int QUEUE_DEPTH    = 2,
  parameter int COMPUTE_CYCLES = 8,
  parameter int NUM_WB         = 14,
  localparam int BW            = $clog2(NUM_WB + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic [NW_WIDTH-1:0]  in_wid,
  input  logic [META_W-1:0]    in_meta,
  output logic                 in_ready,
  output logic                 wb_valid,
  input  logic                 wb_ready,
  output logic [NW_WIDTH-1:0]  wb_wid,
  output logic [META_W-1:0]    wb_meta,
  output logic [BW-1:0]        wb_idx,
  output logic                 wb_last,
  output logic [NUM_WARPS-1:0] warp_busy,
  output logic                 idle
);

  localparam int PW  = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int CW  = $clog2(QUEUE_DEPTH + 1);
  localparam int CCW = (COMPUTE_CYCLES > 1) ? $clog2(COMPUTE_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, COMPUTE, WRITEBACK} state_t;

  state_t               state;
  logic [NW_WIDTH-1:0]  active_wid;
  logic [NW_WIDTH-1:0]  rr_ptr;
  logic [CCW-1:0]       cyc;
  logic [BW-1:0]        beat;
  logic [CW-1:0]        count  [NUM_WARPS];
  logic [PW-1:0]        rd_ptr [NUM_WARPS];
  logic [PW-1:0]        wr_ptr [NUM_WARPS];
  logic [META_W-1:0]    mem    [NUM_WARPS][QUEUE_DEPTH];

  logic                 fire;
  logic                 pop;
  logic                 last_beat;
  logic [NUM_WARPS-1:0] push_vec;
  logic [NUM_WARPS-1:0] pop_vec;
  logic                 grant_valid;
  logic [NW_WIDTH-1:0]  grant_wid;
  int                   grant_idx;

  assign in_ready  = (count[in_wid] != CW'(QUEUE_DEPTH));
  assign fire      = in_valid && in_ready;
  assign last_beat = (beat == BW'(NUM_WB - 1));
  assign pop       = (state == WRITEBACK) && wb_ready && last_beat;

  always_comb begin
    push_vec  = '0;
    pop_vec   = '0;
    warp_busy = '0;
    for (int w = 0; w < NUM_WARPS; w++) begin
      push_vec[w]  = fire && (in_wid == NW_WIDTH'(w));
      pop_vec[w]   = pop && (active_wid == NW_WIDTH'(w));
      warp_busy[w] = (count[w] != '0);
    end
  end

  // Descending scan so the nearest non-empty warp at or after rr_ptr wins.
  always_comb begin
    grant_valid = 1'b0;
    grant_wid   = '0;
    grant_idx   = 0;
    for (int i = NUM_WARPS - 1; i >= 0; i--) begin
      grant_idx = (int'(rr_ptr) + i) % NUM_WARPS;
      if (count[NW_WIDTH'(grant_idx)] != '0) begin
        grant_valid = 1'b1;
        grant_wid   = NW_WIDTH'(grant_idx);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (fire) mem[in_wid][wr_ptr[in_wid]] <= in_meta;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int w = 0; w < NUM_WARPS; w++) begin
        count[w]  <= '0;
        rd_ptr[w] <= '0;
        wr_ptr[w] <= '0;
      end
    end else begin
      for (int w = 0; w < NUM_WARPS; w++) begin
        if (push_vec[w]) wr_ptr[w] <= wr_ptr[w] + PW'(1);
        if (pop_vec[w])  rd_ptr[w] <= rd_ptr[w] + PW'(1);
        if (push_vec[w] && !pop_vec[w])      count[w] <= count[w] + CW'(1);
        else if (!push_vec[w] && pop_vec[w]) count[w] <= count[w] - CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      active_wid <= '0;
      rr_ptr     <= '0;
      cyc        <= '0;
      beat       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_valid) begin
            active_wid <= grant_wid;
            cyc        <= '0;
            state      <= COMPUTE;
            rr_ptr     <= (grant_wid == NW_WIDTH'(NUM_WARPS - 1)) ? '0 : grant_wid + NW_WIDTH'(1);
          end
        end
        COMPUTE: begin
          if (cyc == CCW'(COMPUTE_CYCLES - 1)) begin
            beat  <= '0;
            state <= WRITEBACK;
          end else begin
            cyc <= cyc + CCW'(1);
          end
        end
        WRITEBACK: begin
          if (wb_ready) begin
            if (last_beat) begin
              beat  <= '0;
              state <= IDLE;
            end else begin
              beat <= beat + BW'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign wb_valid = (state == WRITEBACK);
  assign wb_last  = wb_valid && last_beat;
  assign wb_idx   = beat;
  assign wb_wid   = active_wid;
  assign wb_meta  = (state != IDLE) ? mem[active_wid][rd_ptr[active_wid]] : '0;
  assign idle     = (state == IDLE) && !(|warp_busy);

  a_no_push_full: assert property (@(posedge clk) disable iff (!reset)
    (in_valid && in_ready) |-> (count[in_wid] != CW'(QUEUE_DEPTH)));
  a_valid_hold: assert property (@(posedge clk) disable iff (!reset)
    (wb_valid && !wb_ready) |=> wb_valid);
  a_active_nonempty: assert property (@(posedge clk) disable iff (!reset)
    (state != IDLE) |-> (count[active_wid] != '0));

endmodule

// File: tb/tb_vx_tensor_wgmma_sequencer.sv
// Self-checking bench: directed scenarios plus random traffic against a queue-based
// behavioural model of warp arbitration, compute delay and writeback beats.
module tb_vx_tensor_wgmma_sequencer;

  localparam int NUM_WARPS      = 4;
  localparam int NW_WIDTH       = 2;
  localparam int META_W         = 64;
  localparam int QUEUE_DEPTH    = 2;
  localparam int COMPUTE_CYCLES = 8;
  localparam int NUM_WB         = 14;
  localparam int BW             = $clog2(NUM_WB + 1);

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 in_valid;
  logic [NW_WIDTH-1:0]  in_wid;
  logic [META_W-1:0]    in_meta;
  logic                 in_ready;
  logic                 wb_valid;
  logic                 wb_ready;
  logic [NW_WIDTH-1:0]  wb_wid;
  logic [META_W-1:0]    wb_meta;
  logic [BW-1:0]        wb_idx;
  logic                 wb_last;
  logic [NUM_WARPS-1:0] warp_busy;
  logic                 idle;

  vx_tensor_wgmma_sequencer #(
    .NUM_WARPS(NUM_WARPS), .NW_WIDTH(NW_WIDTH), .META_W(META_W),
    .QUEUE_DEPTH(QUEUE_DEPTH), .COMPUTE_CYCLES(COMPUTE_CYCLES), .NUM_WB(NUM_WB)
  ) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_wid(in_wid), .in_meta(in_meta),
    .in_ready(in_ready), .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_wid(wb_wid),
    .wb_meta(wb_meta), .wb_idx(wb_idx), .wb_last(wb_last), .warp_busy(warp_busy), .idle(idle)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;

  // Behavioural model: one queue per warp plus the in-flight operation.
  logic [META_W-1:0] mq [NUM_WARPS][$];
  bit m_busy;
  int m_wid, m_left, m_beat, m_rr;

  // DUT observations gathered at each sampling point.
  bit obs_valid, obs_idle;
  int obs_fires, obs_lasts, obs_last_idx, obs_wbcyc;
  int obs_order[$];

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic modelClear();
    for (int w = 0; w < NUM_WARPS; w++) mq[w].delete();
    m_busy = 0; m_wid = 0; m_left = 0; m_beat = 0; m_rr = 0;
  endtask

  task automatic resetObs();
    obs_fires = 0; obs_lasts = 0; obs_last_idx = -1; obs_wbcyc = 0;
    obs_order.delete();
  endtask

  function automatic bit expValid();
    return m_busy && (m_left == 0);
  endfunction

  task automatic compareAll();
    logic [NUM_WARPS-1:0] busy_exp;
    bit any;
    busy_exp = '0;
    any = 0;
    for (int w = 0; w < NUM_WARPS; w++) begin
      busy_exp[w] = (mq[w].size() > 0);
      any |= busy_exp[w];
    end
    checkOutput("wb_valid", wb_valid, expValid());
    checkOutput("wb_last", wb_last, expValid() && (m_beat == NUM_WB - 1));
    checkOutput("wb_idx", wb_idx, m_beat);
    checkOutput("wb_meta", wb_meta, m_busy ? mq[m_wid][0] : 64'd0);
    if (m_busy) checkOutput("wb_wid", wb_wid, m_wid);
    checkOutput("warp_busy", warp_busy, busy_exp);
    checkOutput("idle", idle, !m_busy && !any);
    checkOutput("in_ready", in_ready, mq[in_wid].size() < QUEUE_DEPTH);
    obs_valid = wb_valid;
    obs_idle  = idle;
    if (wb_valid) obs_wbcyc++;
    if (wb_valid && wb_ready) begin
      obs_fires++;
      if (wb_last) begin
        obs_lasts++;
        obs_last_idx = wb_idx;
        obs_order.push_back(int'(wb_wid));
      end
    end
  endtask

  task automatic modelUpdate();
    bit do_push, found;
    int g;
    if (!reset) begin
      modelClear();
      return;
    end
    do_push = in_valid && (mq[in_wid].size() < QUEUE_DEPTH);
    found = 0;
    g = 0;
    if (!m_busy) begin
      for (int i = 0; i < NUM_WARPS; i++) begin
        int w;
        w = (m_rr + i) % NUM_WARPS;
        if (!found && mq[w].size() > 0) begin
          found = 1;
          g = w;
        end
      end
      if (found) begin
        m_busy = 1; m_wid = g; m_left = COMPUTE_CYCLES; m_beat = 0;
        m_rr = (g + 1) % NUM_WARPS;
      end
    end else if (m_left > 0) begin
      m_left--;
    end else if (wb_ready) begin
      if (m_beat == NUM_WB - 1) begin
        void'(mq[m_wid].pop_front());
        m_busy = 0;
        m_beat = 0;
      end else begin
        m_beat++;
      end
    end
    if (do_push) mq[in_wid].push_back(in_meta);
  endtask

  // One clock: drive inputs, compare at the falling edge, advance the model at the rising edge.
  task automatic applyStimulus(input logic v, input int w, input logic [63:0] m, input logic r);
    in_valid = v;
    in_wid   = NW_WIDTH'(w);
    in_meta  = m;
    wb_ready = r;
    @(negedge clk);
    compareAll();
    @(posedge clk);
    modelUpdate();
    #1;
  endtask

  task automatic runToIdle(input string tag);
    int k = 0;
    do begin
      applyStimulus(0, 0, 64'd0, 1);
      k++;
    end while (!obs_idle && k < 400);
    checkOutput(tag, obs_idle, 1);
  endtask

  function automatic logic [63:0] rndMeta();
    return {$urandom, $urandom};
  endfunction

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int n;
    int r;
    reset = 1'b0; in_valid = 0; in_wid = '0; in_meta = '0; wb_ready = 0;
    modelClear();
    resetObs();
    repeat (2) @(posedge clk);
    #1;
    compareAll();
    reset = 1'b1;

    // Single op on warp 0 with wb_ready held high.
    applyStimulus(1, 0, rndMeta(), 1);
    applyStimulus(0, 0, 64'd0, 1);
    resetObs();
    n = 0;
    do begin
      applyStimulus(0, 0, 64'd0, 1);
      n++;
    end while (!obs_valid && n < 50);
    checkOutput("latency", n, COMPUTE_CYCLES + 1);
    runToIdle("single_idle");
    checkOutput("single_fires", obs_fires, NUM_WB);
    checkOutput("single_lasts", obs_lasts, 1);
    checkOutput("single_last_idx", obs_last_idx, NUM_WB - 1);

    // Backpressure: ready alternates 1/0 starting on the first writeback cycle.
    applyStimulus(1, 0, rndMeta(), 1);
    resetObs();
    n = 0;
    r = 0;
    do begin
      if (expValid()) begin
        applyStimulus(0, 0, 64'd0, (r % 2) == 0);
        r++;
      end else begin
        applyStimulus(0, 0, 64'd0, 1);
      end
      n++;
    end while (!obs_idle && n < 400);
    checkOutput("bp_fires", obs_fires, NUM_WB);
    checkOutput("bp_wb_cycles", obs_wbcyc, 2 * NUM_WB - 1);

    // Fairness: op on warp 3 leaves rr at 0, then 2, 0, 3 queue behind it.
    resetObs();
    applyStimulus(1, 3, rndMeta(), 1);
    applyStimulus(0, 0, 64'd0, 1);
    applyStimulus(1, 2, rndMeta(), 1);
    applyStimulus(1, 0, rndMeta(), 1);
    applyStimulus(1, 3, rndMeta(), 1);
    runToIdle("fair_idle");
    n = 0;
    do begin
      if (obs_idle) n = 999;
      else applyStimulus(0, 0, 64'd0, 1);
    end while (n < 999);
    checkOutput("fair_count", obs_order.size(), 4);
    if (obs_order.size() == 4) begin
      checkOutput("fair_0", obs_order[0], 3);
      checkOutput("fair_1", obs_order[1], 0);
      checkOutput("fair_2", obs_order[2], 2);
      checkOutput("fair_3", obs_order[3], 3);
    end

    // Full queue on warp 1 while warp 0 stays open.
    resetObs();
    applyStimulus(1, 1, rndMeta(), 1);
    applyStimulus(1, 1, rndMeta(), 1);
    in_valid = 0;
    in_wid = 2'd1;
    #1 checkOutput("full_w1", in_ready, 0);
    in_wid = 2'd0;
    #1 checkOutput("open_w0", in_ready, 1);
    n = 0;
    do begin
      applyStimulus(0, 1, 64'd0, 1);
      n++;
    end while (obs_lasts == 0 && n < 100);
    #1 checkOutput("reopen_w1", in_ready, 1);
    runToIdle("full_idle");

    // Push to the active warp on the cycle of its last-beat pop.
    applyStimulus(1, 2, rndMeta(), 1);
    n = 0;
    while (!(expValid() && m_beat == NUM_WB - 1) && n < 100) begin
      applyStimulus(0, 0, 64'd0, 1);
      n++;
    end
    applyStimulus(1, 2, rndMeta(), 1);
    #1 checkOutput("simul_busy2", warp_busy[2], 1);
    runToIdle("simul_idle");

    // Asynchronous reset in the middle of writeback.
    applyStimulus(1, 1, rndMeta(), 1);
    n = 0;
    while (!(expValid() && m_beat == 5) && n < 100) begin
      applyStimulus(0, 0, 64'd0, 1);
      n++;
    end
    checkOutput("rst_reached_beat5", wb_idx, 5);
    reset = 1'b0;
    #1;
    modelClear();
    checkOutput("rst_valid", wb_valid, 0);
    checkOutput("rst_busy", warp_busy, 0);
    checkOutput("rst_idle", idle, 1);
    applyStimulus(0, 0, 64'd0, 1);
    applyStimulus(0, 0, 64'd0, 1);
    reset = 1'b1;
    resetObs();
    repeat (30) applyStimulus(0, 0, 64'd0, 1);
    checkOutput("rst_no_stale", obs_wbcyc, 0);

    // Random traffic with random backpressure.
    for (int i = 0; i < 2500; i++) begin
      applyStimulus($urandom_range(0, 9) < 3, $urandom_range(0, NUM_WARPS - 1), rndMeta(),
                    $urandom_range(0, 9) < 7);
    end
    runToIdle("random_idle");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/vx_tensor_wgmma_sequencer.md
Name: vx_tensor_wgmma_sequencer

Overview:
- Multi-warp successor to the single-warp tensor-core commit sequencer; sits between the tensor execute dispatch and the commit stage.
- Buffers per-warp instruction metadata in independent queues and round-robin selects one warp per operation.
- Runs a programmable compute phase, then emits a parametrised number of writeback beats with valid/ready, flagging the last beat.
- Releases the metadata on the last writeback.

Parameters:
- NUM_WARPS, 4, number of warps with independent metadata queues (>=1).
- NW_WIDTH, 2, warp-id width, max(1, clog2(NUM_WARPS)).
- META_W, 64, width of opaque per-instruction metadata (uuid/tmask/PC/rd etc., packed by the caller).
- QUEUE_DEPTH, 2, entries per warp queue (power of 2, >=2).
- COMPUTE_CYCLES, 8, cycles spent in COMPUTE before the first writeback beat (>=1).
- NUM_WB, 14, writeback beats per operation (>=1).

Ports:
- clk, input, 1, clock.
- reset, input, 1, asynchronous active-low reset: 0 = in reset, 1 = run; async assert, sync deassert by the caller.
- in_valid, input, 1, new tensor instruction offered.
- in_wid, input, NW_WIDTH, issuing warp.
- in_meta, input, META_W, metadata to hold until retire.
- in_ready, output, 1, queue of in_wid not full.
- wb_valid, output, 1, writeback beat valid.
- wb_ready, input, 1, commit accepts beat.
- wb_wid, output, NW_WIDTH, warp of current operation.
- wb_meta, output, META_W, head metadata of active warp.
- wb_idx, output, clog2(NUM_WB+1), beat index 0..NUM_WB-1.
- wb_last, output, 1, beat is final (wb_idx==NUM_WB-1).
- warp_busy, output, NUM_WARPS, bit i = queue i non-empty.
- idle, output, 1, FSM in IDLE and all queues empty.

Behaviour:
- Reset (reset==0): all queues empty, FSM=IDLE, RR pointer=0, counters=0.
  - Outputs during reset: wb_valid=0, wb_last=0, wb_idx=0, wb_wid=0, warp_busy=0, idle=1.
  - in_ready=1, combinational on in_wid.
  - Reset mid-operation discards all queued and in-flight work; no partial beats.
- Enqueue: fire = in_valid && in_ready; pushes in_meta into queue[in_wid].
  - in_ready = !full[in_wid]; other warps' queues are unaffected.
  - The first entry is visible to the arbiter the next cycle.
- FSM states: IDLE -> COMPUTE -> WRITEBACK -> IDLE.
  - IDLE: if any queue is non-empty, grant the first non-empty warp at or after the RR pointer.
    - Latch it as active wid; set cycle counter=0; go to COMPUTE.
    - RR pointer <= grant+1, wrapping at NUM_WARPS.
  - COMPUTE: counter increments each cycle; when counter==COMPUTE_CYCLES-1, go to WRITEBACK with beat=0.
    - wb_valid=0 throughout.
  - WRITEBACK: wb_valid=1.
    - On wb_valid && wb_ready: beat++.
    - On the firing beat with wb_last=1: pop the head of queue[active], then go to IDLE.
    - Outputs hold stable while wb_ready=0.
- Latency: grant in cycle T, first wb_valid in cycle T+1+COMPUTE_CYCLES; minimum per-op occupancy = 1+COMPUTE_CYCLES+NUM_WB cycles. No overlap between operations.
- wb_meta/wb_wid reflect the active warp's head entry throughout COMPUTE and WRITEBACK. wb_meta is don't-care in IDLE; drive 0.
- Simultaneous push to the active warp during the last-beat pop is legal.
  - in_ready uses the pre-pop full flag (no bypass).
  - Queue count stays unchanged.
- Pushes to a non-active warp during WRITEBACK proceed independently.
- Beat counter width: clog2(NUM_WB+1); NUM_WB=1 gives wb_last on the first beat.
- Assertions:
  - No push when full.
  - wb_valid never drops without a fire.
  - Active queue non-empty outside IDLE.

Test Plan:
- Single op, warp 0, COMPUTE_CYCLES=8, NUM_WB=14, wb_ready=1 -> wb_valid rises 9 cycles after the grant cycle.
  - 14 beats with wb_idx 0..13; wb_last only on beat 13.
  - warp_busy[0] clears the cycle after the last beat; idle=1.
- Backpressure: wb_ready toggles 1/0 each cycle -> exactly 14 fires.
  - wb_idx and wb_meta stay stable across stalls; total WRITEBACK length 27 cycles.
- Fairness: push warps 2, 0, 3 in the same window with RR pointer=0 -> service order 0, 2, 3; wb_wid and wb_meta match the pushed values.
- Full: push 2 entries to warp 1 with QUEUE_DEPTH=2 -> in_ready=0 for wid=1 while in_ready=1 for wid=0.
  - After warp 1's first last-beat fire, in_ready for wid=1 returns to 1 the next cycle.
- Simultaneous: push to the active warp on the cycle of its last-beat pop -> accepted; queue count unchanged; the next op for that warp starts later, after RR arbitration.
- Reset mid-WRITEBACK at beat 5 -> wb_valid=0 immediately (async); after release, warp_busy=0, idle=1, and no stale beats.
